// File: rtl/weight_word_enumerator_if.sv
// Stream interface for weight_word_enumerator: a weight request channel in and
// an enumerated-word channel out. The producer of requests / consumer of words
// uses the master modport; the enumerator uses the slave modport.
// Optional macro WEIGHT_ENUM_INDEX_EN adds the O_idx beat-index signal.
interface weight_word_enumerator_if #(
   parameter int WIDTH = 8
);
   localparam int KW = $clog2(WIDTH + 1);

   logic             req_valid;
   logic             req_ready;
   logic [KW-1:0]    req_k;
   logic [WIDTH-1:0] O;
   logic             O_valid;
   logic             O_ready;
   logic             O_last;
   logic             O_err;
`ifdef WEIGHT_ENUM_INDEX_EN
   logic [WIDTH-1:0] O_idx;
`endif

`ifdef WEIGHT_ENUM_INDEX_EN
   modport master (
      output req_valid, req_k, O_ready,
      input  req_ready, O, O_valid, O_last, O_err, O_idx
   );

   modport slave (
      input  req_valid, req_k, O_ready,
      output req_ready, O, O_valid, O_last, O_err, O_idx
   );
`else
   modport master (
      output req_valid, req_k, O_ready,
      input  req_ready, O, O_valid, O_last, O_err
   );

   modport slave (
      input  req_valid, req_k, O_ready,
      output req_ready, O, O_valid, O_last, O_err
   );
`endif

endinterface

// File: rtl/weight_word_enumerator.sv
// weight_word_enumerator: given a weight k, streams every WIDTH-bit word with
// exactly k set bits in ascending order, flagging the final word. Successive
// words come from Gosper's next-combination step, with the divide by the
// lowest set bit done as a shift by its trailing-zero count.
// Optional macro WEIGHT_ENUM_INDEX_EN adds a zero-based beat index output.
module weight_word_enumerator #(
   parameter int WIDTH = 8,
   localparam int KW = $clog2(WIDTH + 1)
) (
   input  logic CLK,
   input  logic ASYNCRESETN,
   weight_word_enumerator_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [KW-1:0]    k_q, k_d;
   logic             err_q, err_d;
   logic             last;
   logic [WIDTH-1:0] start_word;
   logic [WIDTH-1:0] top_word;
   logic [WIDTH-1:0] low_bit;
   logic [WIDTH-1:0] ripple;
   logic [KW-1:0]    ctz;
   logic [WIDTH-1:0] next_word;
`ifdef WEIGHT_ENUM_INDEX_EN
   logic [WIDTH-1:0] idx_q, idx_d;
`endif

   // First word of a legal request: the k lowest bits set.
   always_comb begin
      start_word = WIDTH'((ONE << bus.req_k) - ONE);
   end

   // Final word for the latched weight: the k highest bits set.
   always_comb begin
      top_word = WIDTH'((ONE << k_q) - ONE) << (KW'(WIDTH) - k_q);
   end

   // Gosper step; overflow of ripple only happens past the last word, which is never taken.
   always_comb begin
      low_bit = word_q & (-word_q);
      ripple  = word_q + low_bit;
      ctz     = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (low_bit[i]) ctz = KW'(i);
      end
      next_word = (((ripple ^ word_q) >> 2) >> ctz) | ripple;
   end

   // Last beat is decided from registered state only, so O_ready never reaches it.
   always_comb begin
      last = (state_q == EMIT) && (err_q || (word_q == top_word));
   end

   // Next-state and next-register logic for the request/emit FSM.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      k_d     = k_q;
      err_d   = err_q;
`ifdef WEIGHT_ENUM_INDEX_EN
      idx_d   = idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = EMIT;
               k_d     = bus.req_k;
`ifdef WEIGHT_ENUM_INDEX_EN
               idx_d   = '0;
`endif
               if (bus.req_k > KW'(WIDTH)) begin
                  word_d = '0;
                  err_d  = 1'b1;
               end else begin
                  word_d = start_word;
                  err_d  = 1'b0;
               end
            end
         end
         EMIT: begin
            if (bus.O_ready) begin
               if (last) begin
                  state_d = IDLE;
               end else begin
                  word_d = next_word;
`ifdef WEIGHT_ENUM_INDEX_EN
                  idx_d  = idx_q + WIDTH'(1);
`endif
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) state_q <= IDLE;
      else              state_q <= state_d;
   end

   // Datapath registers: current word, latched weight and error flag.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         word_q <= '0;
         k_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         k_q    <= k_d;
         err_q  <= err_d;
      end
   end

`ifdef WEIGHT_ENUM_INDEX_EN
   // Beat index counter, cleared on acceptance and advanced per handshake.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) idx_q <= '0;
      else              idx_q <= idx_d;
   end

   assign bus.O_idx = idx_q;
`endif

   assign bus.req_ready = (state_q == IDLE);
   assign bus.O_valid   = (state_q == EMIT);
   assign bus.O         = word_q;
   assign bus.O_last    = last;
   assign bus.O_err     = err_q;

endmodule

// File: tb/tb_weight_word_enumerator.sv
// Self-checking bench for weight_word_enumerator: random-backpressure streams
// compared against a reference list of all words of the requested weight.
module tb_weight_word_enumerator;

   localparam int WIDTH = 8;
   localparam int KW    = $clog2(WIDTH + 1);

   logic CLK;
   logic ASYNCRESETN;
   int   testCount = 0;
   int   failCount = 0;

   weight_word_enumerator_if #(.WIDTH(WIDTH)) bus ();

   weight_word_enumerator #(.WIDTH(WIDTH)) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .bus         (bus)
   );

   // Free-running clock, 10 time units per period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference: every word of the given weight in ascending order, or one zero word for an illegal weight.
   task automatic buildExpected(input int k, output int expQ[$]);
      expQ = {};
      if (k > WIDTH) begin
         expQ.push_back(0);
      end else begin
         for (int w = 0; w < (1 << WIDTH); w++) begin
            if ($countones(w) == k) expQ.push_back(w);
         end
      end
   endtask

   // Issue one request and consume its stream; abortAfter >= 0 resets mid-stall after that many beats.
   task automatic applyStimulus(input int k, input int readyPct, input bit holdValid, input int abortAfter);
      int expQ[$];
      int idx;
      int cycles;
      int waitCycles;
      bit rdy;
      bit isErr;
      buildExpected(k, expQ);
      isErr = (k > WIDTH);
      idx = 0;
      cycles = 0;
      waitCycles = 0;
      while (!bus.req_ready && waitCycles < 20) begin
         @(negedge CLK);
         waitCycles++;
      end
      checkOutput("req_ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_k     = KW'(k);
      @(posedge CLK);
      #1;
      bus.req_valid = holdValid;
      bus.req_k     = KW'($urandom_range(WIDTH + 2));
      while (expQ.size() > 0 && cycles < 2000) begin
         @(negedge CLK);
         cycles++;
         checkOutput("O_valid", 32'(bus.O_valid), 32'd1);
         checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
         checkOutput("O", 32'(bus.O), 32'(expQ[0]));
         checkOutput("O_last", 32'(bus.O_last), 32'(expQ.size() == 1));
         checkOutput("O_err", 32'(bus.O_err), 32'(isErr));
`ifdef WEIGHT_ENUM_INDEX_EN
         checkOutput("O_idx", 32'(bus.O_idx), 32'(idx));
`endif
         if (abortAfter >= 0 && idx == abortAfter) begin
            bus.O_ready = 1'b0;
            @(posedge CLK);
            #2;
            ASYNCRESETN = 1'b0;
            #1;
            checkOutput("abort_O_valid", 32'(bus.O_valid), 32'd0);
            checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
            checkOutput("abort_O_last", 32'(bus.O_last), 32'd0);
            @(negedge CLK);
            ASYNCRESETN = 1'b1;
            return;
         end
         rdy = ($urandom_range(99) < readyPct);
         bus.O_ready = rdy;
         @(posedge CLK);
         if (rdy) begin
            void'(expQ.pop_front());
            idx++;
         end
      end
      if (expQ.size() > 0) checkOutput("stream_timeout", 32'd1, 32'd0);
      @(negedge CLK);
      checkOutput("after_O_valid", 32'(bus.O_valid), 32'd0);
      checkOutput("after_req_ready", 32'(bus.req_ready), 32'd1);
      bus.O_ready = 1'b0;
   endtask

   // Test sequence: reset values, boundary weights, backpressure, mid-stream reset, back-to-back.
   initial begin
      ASYNCRESETN   = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_k     = '0;
      bus.O_ready   = 1'b0;
      #12;
      checkOutput("rst_O_valid", 32'(bus.O_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rst_O", 32'(bus.O), 32'd0);
      checkOutput("rst_O_last", 32'(bus.O_last), 32'd0);
      checkOutput("rst_O_err", 32'(bus.O_err), 32'd0);
`ifdef WEIGHT_ENUM_INDEX_EN
      checkOutput("rst_O_idx", 32'(bus.O_idx), 32'd0);
`endif
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      @(negedge CLK);

      applyStimulus(2, 100, 1'b0, -1);
      applyStimulus(0, 100, 1'b0, -1);
      applyStimulus(WIDTH, 100, 1'b0, -1);
      applyStimulus(WIDTH + 1, 100, 1'b0, -1);
      applyStimulus(4, 60, 1'b0, -1);
      applyStimulus(3, 50, 1'b0, 5);
      applyStimulus(1, 100, 1'b0, -1);
      applyStimulus(5, 80, 1'b1, -1);
      applyStimulus(2, 70, 1'b1, -1);
      applyStimulus(1, 100, 1'b0, -1);
      for (int n = 0; n < 6; n++) begin
         applyStimulus(int'($urandom_range(WIDTH + 2)), int'($urandom_range(30, 100)), 1'(($urandom_range(1))), -1);
      end
      bus.req_valid = 1'b0;
      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
